// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Package : bnn_pkg
// Brief   : Shared constants for the BPU group sequencer: FSM state codes,
//           instruction field positions and load sizes.
// Rev     : 1.0 - initial release
// ============================================================================
package bnn_pkg;

  // Sequencer states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOAD_WGT = 3'd1;
  localparam state_t ST_LOAD_IMG = 3'd2;
  localparam state_t ST_CMP0     = 3'd3;
  localparam state_t ST_CMP1     = 3'd4;
  localparam state_t ST_SHIFT    = 3'd5;
  localparam state_t ST_DRAIN    = 3'd6;

  // bpug_instr field layout
  localparam int IMG_EN_BIT = 7;
  localparam int WGT_EN_BIT = 6;
  localparam int DSEL_BIT   = 5;
  localparam int OP_LSB     = 0;
  localparam int OP_W       = 5;

  localparam logic [OP_W-1:0] OP_NOP = 5'd0;

  // Load sizes: 8 BPUs x 7 weights, 7-column image window
  localparam int WGT_WORDS = 56;
  localparam int WIN_COLS  = 7;

endpackage : bnn_pkg
`default_nettype wire

// File: rtl/bpug_res_delay.sv
`default_nettype none
// ============================================================================
// Module : bpug_res_delay
// Brief  : LAT-deep valid/tag shift line that tracks compute issues until
//          their BPU results are ready; empty flag lets the sequencer drain.
// Rev    : 1.0 - initial release
// ============================================================================
module bpug_res_delay #(
  parameter int LAT   = 2,
  parameter int TAG_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_empty
);

  logic [LAT-1:0]   r_vld;
  logic [TAG_W-1:0] r_tag [LAT];

  // Shift entries one stage per cycle; stage 0 takes the new issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
    end else begin
      r_vld[0] <= i_push;
      r_tag[0] <= i_tag;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign o_valid = r_vld[LAT-1];
  assign o_tag   = r_tag[LAT-1];
  assign o_empty = ~|r_vld;

endmodule : bpug_res_delay
`default_nettype wire

// File: rtl/bpug_seq.sv
`default_nettype none
// ============================================================================
// Module : bpug_seq
// Brief  : BPU group sequencer. Streams weights and image columns into the
//          group, slides the 7-column window across the band issuing two
//          compute ops per position, and captures the tagged results.
// Rev    : 1.0 - initial release
// ============================================================================
module bpug_seq #(
  parameter int WGT_WORDS = bnn_pkg::WGT_WORDS,
  parameter int WIN_COLS  = bnn_pkg::WIN_COLS,
  parameter int PIPE_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cfg_cols,
  input  logic [4:0]  cfg_op,
  input  logic        cfg_keep_wgt,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        bpug_sel,
  output logic [7:0]  bpug_instr,
  output logic [7:0]  bpug_data,
  input  logic [55:0] bpu_out,
  output logic        res_valid,
  output logic [55:0] res_data,
  output logic [7:0]  res_col,
  output logic        res_half,
  output logic        busy,
  output logic        done,
  output logic        err
);

  import bnn_pkg::*;

  localparam logic [7:0] c_wgt_last  = 8'(WGT_WORDS - 1);
  localparam logic [7:0] c_img_last  = 8'(WIN_COLS - 1);
  localparam logic [7:0] c_win_cols  = 8'(WIN_COLS);
  localparam logic [7:0] c_instr_wgt = 8'(1 << WGT_EN_BIT);
  localparam logic [7:0] c_instr_img = 8'(1 << IMG_EN_BIT);

  state_t          r_state;
  state_t          w_nxt;
  logic [7:0]      r_cols;
  logic [OP_W-1:0] r_op;
  logic [7:0]      r_bcnt;
  logic [7:0]      r_wcnt;

  logic        r_s_ready, r_sel, r_busy, r_done, r_err, r_res_valid, r_res_half;
  logic [7:0]  r_instr, r_data, r_res_col;
  logic [55:0] r_res_data;

  logic        w_accept, w_cfg_ok, w_last_win, w_push;
  logic [7:0]  w_cmp_instr;
  logic        w_dl_valid, w_dl_empty;
  logic [8:0]  w_dl_tag;

  assign w_accept   = s_valid & r_s_ready;
  assign w_cfg_ok   = (cfg_cols >= c_win_cols) && (cfg_op != OP_NOP);
  assign w_last_win = r_wcnt >= (r_cols - c_win_cols);
  assign w_push     = (r_state == ST_CMP0) || (r_state == ST_CMP1);

  // Compute instruction: data_sel picks the upper (CMP1) row half
  always_comb begin
    w_cmp_instr                  = '0;
    w_cmp_instr[OP_LSB +: OP_W]  = r_op;
    w_cmp_instr[DSEL_BIT]        = (r_state == ST_CMP1);
  end

  // Next-state selection
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (start && w_cfg_ok) w_nxt = cfg_keep_wgt ? ST_LOAD_IMG : ST_LOAD_WGT;
      ST_LOAD_WGT: if (w_accept && (r_bcnt == c_wgt_last)) w_nxt = ST_LOAD_IMG;
      ST_LOAD_IMG: if (w_accept && (r_bcnt == c_img_last)) w_nxt = ST_CMP0;
      ST_CMP0:     w_nxt = ST_CMP1;
      ST_CMP1:     w_nxt = w_last_win ? ST_DRAIN : ST_SHIFT;
      ST_SHIFT:    if (w_accept) w_nxt = ST_CMP0;
      ST_DRAIN:    if (w_dl_empty) w_nxt = ST_IDLE;
      default:     w_nxt = ST_IDLE;
    endcase
  end

  // Tags ride alongside each compute issue until its result is ready
  bpug_res_delay #(
    .LAT   (PIPE_LAT),
    .TAG_W (9)
  ) u_res_delay (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_tag   ({r_wcnt, (r_state == ST_CMP1)}),
    .o_valid (w_dl_valid),
    .o_tag   (w_dl_tag),
    .o_empty (w_dl_empty)
  );

  // State, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cols      <= '0;
      r_op        <= '0;
      r_bcnt      <= '0;
      r_wcnt      <= '0;
      r_s_ready   <= 1'b0;
      r_sel       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_instr     <= '0;
      r_data      <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_col   <= '0;
      r_res_half  <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_busy    <= (w_nxt != ST_IDLE);
      r_sel     <= (w_nxt != ST_IDLE);
      r_s_ready <= (w_nxt == ST_LOAD_WGT) || (w_nxt == ST_LOAD_IMG) || (w_nxt == ST_SHIFT);
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_instr   <= '0;

      case (r_state)
        ST_IDLE: begin
          r_bcnt <= '0;
          r_wcnt <= '0;
          if (start) begin
            if (w_cfg_ok) begin
              r_cols <= cfg_cols;
              r_op   <= cfg_op;
            end else begin
              r_err  <= 1'b1;
            end
          end
        end
        ST_LOAD_WGT: if (w_accept) begin
          r_instr <= c_instr_wgt;
          r_data  <= s_data;
          r_bcnt  <= (r_bcnt == c_wgt_last) ? 8'd0 : r_bcnt + 8'd1;
        end
        ST_LOAD_IMG: if (w_accept) begin
          r_instr <= c_instr_img;
          r_data  <= s_data;
          r_bcnt  <= r_bcnt + 8'd1;
        end
        ST_CMP0, ST_CMP1: r_instr <= w_cmp_instr;
        ST_SHIFT: if (w_accept) begin
          r_instr <= c_instr_img;
          r_data  <= s_data;
          r_wcnt  <= r_wcnt + 8'd1;
        end
        ST_DRAIN: if (w_dl_empty) r_done <= 1'b1;
        default: ;
      endcase

      r_res_valid <= w_dl_valid;
      if (w_dl_valid) begin
        r_res_data <= bpu_out;
        r_res_col  <= w_dl_tag[8:1];
        r_res_half <= w_dl_tag[0];
      end
    end
  end

  assign s_ready    = r_s_ready;
  assign bpug_sel   = r_sel;
  assign bpug_instr = r_instr;
  assign bpug_data  = r_data;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_col    = r_res_col;
  assign res_half   = r_res_half;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule : bpug_seq
`default_nettype wire
